// File: rtl/game_classic_ctrl.sv
// Classic-mode game controller: get-ready countdown, fixed-length play timer
// and a saturating hit counter. All outputs are registered from next-state
// values, so an event in cycle N is visible just after the cycle N+1 edge.
// start/hit/quit are single-cycle pulses from debounced buttons; there is
// no handshake, and a pulse is consumed in the cycle it is high.
module game_classic_ctrl #(
    parameter int TICK_CYCLES   = 100_000_000,
    parameter int GAME_SECONDS  = 16,
    parameter int READY_SECONDS = 3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        hit,
    input  logic        quit,
    output logic        enable_game,
    output logic [15:0] led_level,
    output logic [15:0] seg_value,
    output logic [4:0]  score
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [4:0]    GAME_LEN  = 5'(GAME_SECONDS);
    localparam logic [3:0]    READY_LEN = 4'(READY_SECONDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    ready_cnt_q, ready_cnt_d;
    logic [4:0]    time_left_q, time_left_d;
    logic [4:0]    score_q, score_d;
    logic          enable_game_q, enable_game_d;
    logic [15:0]   led_level_q, led_level_d;
    logic [15:0]   seg_value_q, seg_value_d;
    logic          tick;

    // Binary 0..31 to two packed BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd(input logic [4:0] b);
        logic [3:0] tens;
        logic [3:0] ones;
        if (b >= 5'd30) begin
            tens = 4'd3;
            ones = 4'(b - 5'd30);
        end else if (b >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(b - 5'd20);
        end else if (b >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(b - 5'd10);
        end else begin
            tens = 4'd0;
            ones = b[3:0];
        end
        return {tens, ones};
    endfunction

    // The second tick fires only while the counter is running (READY/PLAY).
    assign tick = (state_q == READY || state_q == PLAY) && (tick_cnt_q == TICK_LAST);

    // Next-state, counters and registered output values.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = '0;
        ready_cnt_d = ready_cnt_q;
        time_left_d = time_left_q;
        score_d     = score_q;

        case (state_q)
            IDLE, OVER: begin
                // start outranks a simultaneous quit here
                if (start) begin
                    state_d     = READY;
                    score_d     = '0;
                    ready_cnt_d = READY_LEN;
                end
            end
            READY: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                if (quit) begin
                    state_d    = OVER;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    ready_cnt_d = ready_cnt_q - 4'd1;
                    if (ready_cnt_q == 4'd1) begin
                        state_d     = PLAY;
                        time_left_d = GAME_LEN;
                    end
                end
            end
            PLAY: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                if (quit) begin
                    // a hit in the quit cycle is dropped
                    state_d    = OVER;
                    tick_cnt_d = '0;
                end else begin
                    // a hit on the final tick still counts
                    if (hit && score_q != 5'd31) score_d = score_q + 5'd1;
                    if (tick) begin
                        time_left_d = time_left_q - 5'd1;
                        if (time_left_q == 5'd1) state_d = OVER;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        enable_game_d = 1'b0;
        led_level_d   = '0;
        seg_value_d   = '0;
        case (state_d)
            READY: begin
                enable_game_d = 1'b1;
                led_level_d   = 16'(GAME_LEN);
                seg_value_d   = {12'h000, ready_cnt_d};
            end
            PLAY: begin
                enable_game_d = 1'b1;
                led_level_d   = 16'(time_left_d);
                seg_value_d   = {to_bcd(time_left_d), to_bcd(score_d)};
            end
            OVER: begin
                seg_value_d   = {8'h00, to_bcd(score_d)};
            end
            default: ;
        endcase
    end

    // State and output registers, cleared asynchronously by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            ready_cnt_q   <= '0;
            time_left_q   <= '0;
            score_q       <= '0;
            enable_game_q <= 1'b0;
            led_level_q   <= '0;
            seg_value_q   <= '0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            ready_cnt_q   <= ready_cnt_d;
            time_left_q   <= time_left_d;
            score_q       <= score_d;
            enable_game_q <= enable_game_d;
            led_level_q   <= led_level_d;
            seg_value_q   <= seg_value_d;
        end
    end

    assign enable_game = enable_game_q;
    assign led_level   = led_level_q;
    assign seg_value   = seg_value_q;
    assign score       = score_q;

endmodule

// File: tb/tb_game_classic_ctrl.sv
// Directed bench for game_classic_ctrl. The main instance uses TICK_CYCLES=4,
// GAME_SECONDS=5, READY_SECONDS=3 (READY 12 cycles, PLAY 20 cycles). A second
// instance with TICK_CYCLES=16, READY_SECONDS=1 gives a PLAY window long
// enough (80 cycles) to push the score into saturation.
module tb_game_classic_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        start, hit, quit;
  logic        enable_game;
  logic [15:0] led_level, seg_value;
  logic [4:0]  score;

  logic        start2, hit2, quit2;
  logic        enable_game2;
  logic [15:0] led_level2, seg_value2;
  logic [4:0]  score2;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  game_classic_ctrl #(.TICK_CYCLES(4), .GAME_SECONDS(5), .READY_SECONDS(3)) dut (
    .clk(clk), .clr(clr), .start(start), .hit(hit), .quit(quit),
    .enable_game(enable_game), .led_level(led_level), .seg_value(seg_value), .score(score)
  );

  game_classic_ctrl #(.TICK_CYCLES(16), .GAME_SECONDS(5), .READY_SECONDS(1)) dut2 (
    .clk(clk), .clr(clr), .start(start2), .hit(hit2), .quit(quit2),
    .enable_game(enable_game2), .led_level(led_level2), .seg_value(seg_value2), .score(score2)
  );

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // start from IDLE/OVER and advance to the first PLAY cycle (12 edges later)
  task automatic go_play();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (12) cyc();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    #12;
    checks++;
    if (enable_game !== 1'b0 || led_level !== 16'h0 || seg_value !== 16'h0 || score !== 5'd0) begin
      errors++;
      $display("FAIL reset: en=%b led=%h seg=%h score=%0d, expected all 0", enable_game, led_level, seg_value, score);
    end
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (enable_game !== 1'b0 || led_level !== 16'h0 || seg_value !== 16'h0 || score !== 5'd0) begin
        errors++;
        $display("FAIL idle[%0d]: en=%b led=%h seg=%h score=%0d, expected all 0", i, enable_game, led_level, seg_value, score);
      end
    end
  endtask

  task automatic test_ready();
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (enable_game !== 1'b1 || led_level !== 16'd5 || seg_value !== 16'h0003 || score !== 5'd0) begin
      errors++;
      $display("FAIL ready_entry: en=%b led=%h seg=%h score=%0d, expected 1/0005/0003/0", enable_game, led_level, seg_value, score);
    end
    repeat (3) cyc();
    checks++;
    if (seg_value !== 16'h0003) begin
      errors++;
      $display("FAIL ready_hold3: seg=%h expected 0003", seg_value);
    end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    checks++;
    if (seg_value !== 16'h0002 || score !== 5'd0) begin
      errors++;
      $display("FAIL ready_step2: seg=%h score=%0d expected 0002/0", seg_value, score);
    end
    repeat (4) cyc();
    checks++;
    if (seg_value !== 16'h0001) begin
      errors++;
      $display("FAIL ready_step1: seg=%h expected 0001", seg_value);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (seg_value !== 16'h0001 || enable_game !== 1'b1) begin
      errors++;
      $display("FAIL ready_start_ignored: seg=%h en=%b expected 0001/1", seg_value, enable_game);
    end
    repeat (3) cyc();
    checks++;
    if (seg_value !== 16'h0500 || led_level !== 16'd5 || enable_game !== 1'b1) begin
      errors++;
      $display("FAIL play_entry: seg=%h led=%h en=%b expected 0500/0005/1", seg_value, led_level, enable_game);
    end
  endtask

  // continues from the first PLAY cycle left by test_ready
  task automatic test_play_hits();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    checks++;
    if (score !== 5'd1) begin
      errors++;
      $display("FAIL hit_first: score=%0d expected 1", score);
    end
    cyc();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    cyc();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    checks++;
    if (score !== 5'd3 || seg_value !== 16'h0403 || led_level !== 16'd4) begin
      errors++;
      $display("FAIL hit_three: score=%0d seg=%h led=%h expected 3/0403/0004", score, seg_value, led_level);
    end
    repeat (14) cyc();
    checks++;
    if (enable_game !== 1'b1 || seg_value !== 16'h0103 || led_level !== 16'd1) begin
      errors++;
      $display("FAIL play_last_second: en=%b seg=%h led=%h expected 1/0103/0001", enable_game, seg_value, led_level);
    end
    cyc();
    checks++;
    if (enable_game !== 1'b0 || led_level !== 16'h0 || seg_value !== 16'h0003 || score !== 5'd3) begin
      errors++;
      $display("FAIL over_timeout: en=%b led=%h seg=%h score=%0d expected 0/0000/0003/3", enable_game, led_level, seg_value, score);
    end
  endtask

  task automatic test_final_tick_hit();
    go_play();
    checks++;
    if (score !== 5'd0 || seg_value !== 16'h0500) begin
      errors++;
      $display("FAIL restart_play: score=%0d seg=%h expected 0/0500", score, seg_value);
    end
    hit = 1'b1;
    repeat (19) cyc();
    checks++;
    if (score !== 5'd19 || seg_value !== 16'h0119 || enable_game !== 1'b1) begin
      errors++;
      $display("FAIL hold_hit_19: score=%0d seg=%h en=%b expected 19/0119/1", score, seg_value, enable_game);
    end
    cyc();
    checks++;
    if (score !== 5'd20 || seg_value !== 16'h0020 || enable_game !== 1'b0) begin
      errors++;
      $display("FAIL final_tick_hit: score=%0d seg=%h en=%b expected 20/0020/0", score, seg_value, enable_game);
    end
    cyc();
    hit = 1'b0;
    checks++;
    if (score !== 5'd20 || seg_value !== 16'h0020) begin
      errors++;
      $display("FAIL over_hit_ignored: score=%0d seg=%h expected 20/0020", score, seg_value);
    end
  endtask

  task automatic test_saturate();
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    checks++;
    if (seg_value2 !== 16'h0001 || led_level2 !== 16'd5 || enable_game2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_ready: seg=%h led=%h en=%b expected 0001/0005/1", seg_value2, led_level2, enable_game2);
    end
    repeat (16) cyc();
    checks++;
    if (seg_value2 !== 16'h0500) begin
      errors++;
      $display("FAIL sat_play_entry: seg=%h expected 0500", seg_value2);
    end
    hit2 = 1'b1;
    repeat (31) cyc();
    checks++;
    if (score2 !== 5'd31 || seg_value2 !== 16'h0431) begin
      errors++;
      $display("FAIL sat_reach31: score=%0d seg=%h expected 31/0431", score2, seg_value2);
    end
    repeat (9) cyc();
    hit2 = 1'b0;
    checks++;
    if (score2 !== 5'd31 || seg_value2[7:0] !== 8'h31 || seg_value2 !== 16'h0331) begin
      errors++;
      $display("FAIL sat_hold31: score=%0d seg=%h expected 31/0331", score2, seg_value2);
    end
  endtask

  task automatic test_quit_hit();
    go_play();
    hit = 1'b1;
    repeat (2) cyc();
    quit = 1'b1;
    cyc();
    quit = 1'b0;
    hit = 1'b0;
    checks++;
    if (enable_game !== 1'b0 || led_level !== 16'h0 || seg_value !== 16'h0002 || score !== 5'd2) begin
      errors++;
      $display("FAIL quit_hit: en=%b led=%h seg=%h score=%0d expected 0/0000/0002/2", enable_game, led_level, seg_value, score);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (enable_game !== 1'b1 || seg_value !== 16'h0003 || score !== 5'd0) begin
      errors++;
      $display("FAIL restart_after_quit: en=%b seg=%h score=%0d expected 1/0003/0", enable_game, seg_value, score);
    end
    quit = 1'b1;
    cyc();
    quit = 1'b0;
    checks++;
    if (enable_game !== 1'b0 || seg_value !== 16'h0000 || led_level !== 16'h0) begin
      errors++;
      $display("FAIL quit_ready: en=%b seg=%h led=%h expected 0/0000/0000", enable_game, seg_value, led_level);
    end
    start = 1'b1;
    quit = 1'b1;
    cyc();
    start = 1'b0;
    quit = 1'b0;
    checks++;
    if (enable_game !== 1'b1 || seg_value !== 16'h0003 || led_level !== 16'd5) begin
      errors++;
      $display("FAIL start_beats_quit: en=%b seg=%h led=%h expected 1/0003/0005", enable_game, seg_value, led_level);
    end
  endtask

  // continues from the READY entry left by test_quit_hit
  task automatic test_clr_mid_game();
    repeat (12) cyc();
    hit = 1'b1;
    repeat (7) cyc();
    hit = 1'b0;
    checks++;
    if (score !== 5'd7 || seg_value !== 16'h0407) begin
      errors++;
      $display("FAIL pre_clr: score=%0d seg=%h expected 7/0407", score, seg_value);
    end
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if (enable_game !== 1'b0 || led_level !== 16'h0 || seg_value !== 16'h0 || score !== 5'd0) begin
      errors++;
      $display("FAIL clr_async: en=%b led=%h seg=%h score=%0d expected all 0", enable_game, led_level, seg_value, score);
    end
    cyc();
    clr = 1'b0;
    cyc();
    checks++;
    if (enable_game !== 1'b0 || seg_value !== 16'h0) begin
      errors++;
      $display("FAIL post_clr_idle: en=%b seg=%h expected 0/0000", enable_game, seg_value);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (enable_game !== 1'b1 || led_level !== 16'd5 || seg_value !== 16'h0003 || score !== 5'd0) begin
      errors++;
      $display("FAIL post_clr_ready: en=%b led=%h seg=%h score=%0d expected 1/0005/0003/0", enable_game, led_level, seg_value, score);
    end
    repeat (12) cyc();
    checks++;
    if (seg_value !== 16'h0500 || led_level !== 16'd5 || score !== 5'd0) begin
      errors++;
      $display("FAIL post_clr_play: seg=%h led=%h score=%0d expected 0500/0005/0", seg_value, led_level, score);
    end
  endtask

  initial begin
    start  = 1'b0;
    hit    = 1'b0;
    quit   = 1'b0;
    start2 = 1'b0;
    hit2   = 1'b0;
    quit2  = 1'b0;
    test_reset();
    test_ready();
    test_play_hits();
    test_final_tick_hit();
    test_saturate();
    test_quit_hit();
    test_clr_mid_game();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
